// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines and a line-wide memory port.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_dm_wb #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);
    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = 28 - INDEX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    state_t state;

    logic [LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags  [LINES];
    logic [127:0]     lines [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   atag;
    logic [1:0]         off;
    logic               req, hit;

    assign idx  = proc_addr[INDEX_W+1:2];
    assign atag = proc_addr[29:INDEX_W+2];
    assign off  = proc_addr[1:0];
    assign req  = proc_read | proc_write;
    assign hit  = valid[idx] & (tags[idx] == atag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            valid     <= '0;
            dirty     <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (proc_write) begin
                                lines[idx][{off, 5'b0} +: 32] <= proc_wdata;
                                dirty[idx] <= 1'b1;
                            end
                        end else if (valid[idx] & dirty[idx]) begin
                            state     <= WRITEBACK;
                            mem_write <= 1'b1;
                        end else begin
                            state    <= ALLOCATE;
                            mem_read <= 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state     <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    // The access itself completes in the following IDLE cycle as a hit.
                    if (mem_ready) begin
                        lines[idx] <= mem_rdata;
                        tags[idx]  <= atag;
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        state      <= IDLE;
                        mem_read   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        proc_rdata = '0;
        if (state == IDLE && hit) proc_rdata = lines[idx][{off, 5'b0} +: 32];
    end

    assign proc_stall = rst_n & ((state != IDLE) | (req & ~hit));

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == WRITEBACK) begin
            mem_addr  = {tags[idx], idx};
            mem_wdata = lines[idx];
        end else if (state == ALLOCATE) begin
            mem_addr = proc_addr[29:2];
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_fill;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            post_fill <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            post_fill <= (state == ALLOCATE) & mem_ready;
            if (state == IDLE && req) begin
                if (!hit)            miss_cnt <= miss_cnt + 32'd1;
                else if (!post_fill) hit_cnt  <= hit_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_dcache_dm_wb.sv
// Randomized bench for dcache_dm_wb: a flat word-memory reference gives read data,
// a tag/valid/dirty model gives expected stall lengths and memory traffic.
module tb_dcache_dm_wb;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    dcache_dm_wb #(.INDEX_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .proc_stall(proc_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- slow line memory ----------------
    logic [127:0] mem_lines [logic [27:0]];
    int tmem_cur = 1, mcnt = 0, inj_req = 0, inj_done = 0;

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
    endfunction

    function automatic logic [127:0] backing(input logic [27:0] la);
        logic [127:0] r;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = init_word({la, 2'(w)});
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            mcnt = 0;
        end else begin
            if (mem_ready) begin
                mem_ready = 1'b0;
                mcnt = 0;
            end
            if (inj_req != inj_done) begin
                inj_done = inj_req;
                mem_ready = 1'b1;
            end else if (mem_read || mem_write) begin
                mcnt++;
                if (mcnt >= tmem_cur) begin
                    mem_ready = 1'b1;
                    if (mem_write) mem_lines[mem_addr] = mem_wdata;
                    else           mem_rdata = backing(mem_addr);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [29:0]];
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [24:0] m_tag   [8];
    int exp_hits = 0, exp_miss = 0;

    function automatic logic [31:0] ref_rd(input logic [29:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic preload(input logic [27:0] la, input logic [127:0] line);
        mem_lines[la] = line;
        for (int w = 0; w < 4; w++) ref_mem[{la, 2'(w)}] = line[w*32 +: 32];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        exp_hits = 0;
        exp_miss = 0;
    endtask

    int stalls, wcyc;
    logic [27:0] rd_addr, wr_addr;
    logic [31:0] wr_w0;

    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] d, input int t, input string tag);
        int idx, exp_st;
        bit h, vd;
        logic [24:0] tg;
        idx = int'(a[4:2]);
        tg  = a[29:5];
        h   = m_valid[idx] && (m_tag[idx] == tg);
        vd  = !h && m_valid[idx] && m_dirty[idx];
        exp_st = h ? 0 : (vd ? 1 + 2*t : 1 + t);
        tmem_cur = t;
        proc_addr = a; proc_read = rd; proc_write = wr; proc_wdata = d;
        stalls = 0; wcyc = 0; rd_addr = '1; wr_addr = '1; wr_w0 = '0;
        @(negedge clk);
        while (proc_stall && stalls < 100) begin
            stalls++;
            if (mem_write) begin
                wcyc++;
                wr_addr = mem_addr;
                wr_w0 = mem_wdata[31:0];
            end
            if (mem_read) rd_addr = mem_addr;
            @(negedge clk);
        end
        chk({tag, " stall"}, stalls, exp_st);
        if (!wr) chk({tag, " rdata"}, proc_rdata, ref_rd(a));
        if (!h) begin
            chk({tag, " fetch addr"}, rd_addr, a[29:2]);
            chk({tag, " wb cycles"}, wcyc, vd ? t : 0);
            if (vd) chk({tag, " wb addr"}, wr_addr, {m_tag[idx], 3'(idx)});
        end
        if (h) exp_hits++;
        else begin
            exp_miss++;
            m_valid[idx] = 1;
            m_tag[idx] = tg;
            m_dirty[idx] = 0;
        end
        if (wr) begin
            m_dirty[idx] = 1;
            ref_mem[a] = d;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; proc_read = 0; proc_write = 0; proc_addr = '0; proc_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst stall", proc_stall, 0);
        chk("rst mem_read", mem_read, 0);
        chk("rst mem_write", mem_write, 0);
        chk("rst rdata", proc_rdata, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // first fill
        preload(28'h4, {32'h33333333, 32'h22222222, 32'h11111111, 32'hAABBCCDD});
        access(1, 0, 30'h10, 0, 3, "fill rd");
        chk("fill stall4", stalls, 4);
        chk("fill w0", proc_rdata, 32'hAABBCCDD);
        chk("fill addr", rd_addr, 28'h4);
        access(1, 0, 30'h11, 0, 1, "hit w1");
        chk("hit w1 const", proc_rdata, 32'h11111111);
        access(1, 0, 30'h12, 0, 1, "hit w2");
        access(1, 0, 30'h13, 0, 1, "hit w3");
        chk("hit w3 const", proc_rdata, 32'h33333333);

        // write hit then dirty eviction
        access(1, 1, 30'h10, 32'hDEADBEEF, 1, "wr hit");
        access(1, 0, 30'h10, 0, 1, "rd after wr");
        chk("rd after wr const", proc_rdata, 32'hDEADBEEF);
        access(1, 0, 30'h110, 0, 2, "evict");
        chk("evict stall", stalls, 5);
        chk("evict wb addr", wr_addr, 28'h4);
        chk("evict wb w0", wr_w0, 32'hDEADBEEF);
        chk("evict fetch", rd_addr, 28'h44);

        // write miss to clean line, then conflict
        access(0, 1, 30'h24, 32'h12345678, 2, "wr miss");
        chk("wr miss no wb", wcyc, 0);
        access(1, 0, 30'h24, 0, 1, "rd wr miss");
        chk("rd wr miss const", proc_rdata, 32'h12345678);
        access(1, 0, 30'h124, 0, 1, "conflict");
        chk("conflict wb w0", wr_w0, 32'h12345678);
        chk("conflict wb addr", wr_addr, 28'h9);

`ifdef DCACHE_STATS_EN
        @(negedge clk);
        chk("hit_cnt dir", hit_cnt, exp_hits);
        chk("miss_cnt dir", miss_cnt, exp_miss);
        @(posedge clk); #1;
`endif

        // mem_ready while idle must be ignored
        inj_req++;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle rdy mem_read", mem_read, 0);
        chk("idle rdy mem_write", mem_write, 0);
        chk("idle rdy stall", proc_stall, 0);
        @(posedge clk); #1;
        access(1, 0, 30'h110, 0, 1, "post idle rdy");

        // reset in the middle of a fill
        tmem_cur = 4; proc_addr = 30'h200; proc_read = 1;
        repeat (3) @(negedge clk);
        chk("pre-rst mem_read", mem_read, 1);
        rst_n = 1'b0; proc_read = 0;
        @(negedge clk);
        chk("rst abort mem_read", mem_read, 0);
        chk("rst abort stall", proc_stall, 0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        access(1, 0, 30'h110, 0, 2, "refetch after rst");
        chk("refetch stall", stalls, 3);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            int r, t;
            logic [29:0] a;
            r = $urandom_range(0, 9);
            t = $urandom_range(1, 4);
            a = (30'($urandom_range(0, 3)) << 5) | 30'($urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) a[29:27] = 3'b111;
            access((r >= 4) || (r == 0), r < 4, a, $urandom, t, "rnd");
            if ($urandom_range(0, 4) == 0) begin
                proc_read = 0; proc_write = 0;
                @(posedge clk); #1;
            end
        end

`ifdef DCACHE_STATS_EN
        @(negedge clk);
        chk("hit_cnt end", hit_cnt, exp_hits);
        chk("miss_cnt end", miss_cnt, exp_miss);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
